// File: rtl/rgb_reader_pkg.sv
// Shared types for the RGB frame reader: FSM states, pixel bundle and
// the SRAM word offset of the packed frame.
package rgb_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  localparam logic [17:0] RGB_OFFSET = 18'd146944;

endpackage

// File: rtl/rgb_frame_reader_pixel_fifo.sv
// Synchronous first-word-fall-through FIFO; push and pop in the same
// cycle are accepted even when full.
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_en, rd_en;

  always_comb begin
    full  = cnt_q == CW'(DEPTH);
    empty = cnt_q == '0;
    wr_en = push && (!full || pop);
    rd_en = pop && !empty;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) wptr_d = wptr_q + AW'(1);
    if (rd_en) rptr_d = rptr_q + AW'(1);
    cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
    rdata = mem_q[rptr_q];
    count = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/rgb_frame_reader.sv
// Streams a packed 16-bit RGB frame out of SRAM as 24-bit pixels.
// Define RGB_READER_LOOP_EN to re-read the frame continuously.
module rgb_frame_reader
  import rgb_reader_pkg::*;
#(
  parameter logic [17:0] BASE_ADDR    = RGB_OFFSET,
  parameter int          NUM_PIXELS   = 76800,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          SRAM_LATENCY = 3
) (
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        Start,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        Pix_valid,
  input  logic        Pix_ready,
  output logic [7:0]  Pix_R,
  output logic [7:0]  Pix_G,
  output logic [7:0]  Pix_B,
  output logic        Busy,
  output logic        Done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [17:0] LAST_ADDR =
    18'(int'(BASE_ADDR) + (3 * NUM_PIXELS) / 2 - 1);

  state_t state_q, state_d;

  logic [17:0]             addr_q, addr_d;
  logic [SRAM_LATENCY-1:0] tag_q, tag_d;
  logic [1:0]              phase_q, phase_d;
  logic [7:0]              r_q, r_d;
  logic [7:0]              g_q, g_d;

  logic          issue;
  logic          credit_ok;
  logic          capture;
  logic          inflight_any;
  logic [15:0]   inflight;
  logic [15:0]   load;
  logic          push, pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  pixel_t        push_pix, head_pix;

  // Every in-flight word may still yield one pixel, so it holds a slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < SRAM_LATENCY; i++) begin
      inflight = inflight + 16'(tag_q[i]);
    end
    load = 16'(fifo_count) + inflight
         + 16'(phase_q != 2'd0);
    credit_ok = !fifo_full &&
                (load <= 16'(FIFO_DEPTH - 2));
    issue = (state_q == FETCH) && credit_ok;
    capture = tag_q[SRAM_LATENCY-1];
    inflight_any = |tag_q;
  end

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (Start) state_d = FETCH;
      end
      FETCH: begin
        if (issue && addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && !inflight_any) begin
`ifdef RGB_READER_LOOP_EN
          state_d = FETCH;
`else
          state_d = DONE;
`endif
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy         = state_q != IDLE;
    Done         = state_q == DONE;
    SRAM_we_n    = 1'b1;
    SRAM_address = addr_q;
  end

  always_comb begin
    addr_d = addr_q;
    if (issue && addr_q != LAST_ADDR) begin
      addr_d = addr_q + 18'd1;
    end
    if (state_d == FETCH && state_q != FETCH) begin
      addr_d = BASE_ADDR;
    end
    tag_d[0] = issue;
    for (int i = 1; i < SRAM_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Three words carry two pixels; R/G of the even pixel wait in r_q/g_q.
  always_comb begin
    phase_d  = phase_q;
    r_d      = r_q;
    g_d      = g_q;
    push     = 1'b0;
    push_pix = '0;
    if (capture) begin
      unique case (phase_q)
        2'd0: begin
          r_d     = SRAM_read_data[15:8];
          g_d     = SRAM_read_data[7:0];
          phase_d = 2'd1;
        end
        2'd1: begin
          push       = 1'b1;
          push_pix.r = r_q;
          push_pix.g = g_q;
          push_pix.b = SRAM_read_data[15:8];
          r_d        = SRAM_read_data[7:0];
          phase_d    = 2'd2;
        end
        2'd2: begin
          push       = 1'b1;
          push_pix.r = r_q;
          push_pix.g = SRAM_read_data[15:8];
          push_pix.b = SRAM_read_data[7:0];
          phase_d    = 2'd0;
        end
        default: phase_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      addr_q  <= BASE_ADDR;
      tag_q   <= '0;
      phase_q <= 2'd0;
      r_q     <= 8'd0;
      g_q     <= 8'd0;
    end else begin
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      phase_q <= phase_d;
      r_q     <= r_d;
      g_q     <= g_d;
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pixel_t))
  ) u_fifo (
    .clk   (Clock_50),
    .rst   (Reset),
    .push  (push),
    .wdata (push_pix),
    .pop   (pop),
    .rdata (head_pix),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head is gated so the pixel bus reads zero while nothing is queued.
  always_comb begin
    Pix_valid = !fifo_empty;
    pop       = Pix_valid && Pix_ready;
    Pix_R     = Pix_valid ? head_pix.r : 8'd0;
    Pix_G     = Pix_valid ? head_pix.g : 8'd0;
    Pix_B     = Pix_valid ? head_pix.b : 8'd0;
  end

endmodule

// File: tb/tb_rgb_frame_reader.sv
// Directed bench for rgb_frame_reader: full-size and small-frame DUTs,
// each fed by a 3-cycle SRAM model and checked against a packing model.
module tb_rgb_frame_reader;

  localparam logic [17:0] BASE = 18'd146944;
`ifdef RGB_READER_LOOP_EN
  localparam int NP_B = 4;
`else
  localparam int NP_B = 8;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, st_a, we_a, va, ra, busy_a, done_a;
  logic [17:0] addr_a;
  logic [15:0] rd_a;
  logic [7:0]  r_a, g_a, b_a;

  logic        rst_b, st_b, we_b, vb, rb, busy_b, done_b;
  logic [17:0] addr_b;
  logic [15:0] rd_b;
  logic [7:0]  r_b, g_b, b_b;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word_at(input int off);
    logic [31:0] t;
    if (off == 0) return 16'h1122;
    if (off == 1) return 16'h3344;
    if (off == 2) return 16'h5566;
    t = 32'(off) * 32'd40503 + 32'd7;
    return t[15:0] ^ t[31:16];
  endfunction

  function automatic logic [23:0] ref_pix(input int n);
    int k;
    logic [15:0] w0, w1, w2;
    k  = n / 2;
    w0 = word_at(3 * k);
    w1 = word_at(3 * k + 1);
    w2 = word_at(3 * k + 2);
    if (n % 2 == 0) return {w0, w1[15:8]};
    return {w1[7:0], w2};
  endfunction

  logic [17:0] a1_a, a2_a, a3_a;
  logic [17:0] a1_b, a2_b, a3_b;
  always @(posedge clk) begin
    a1_a <= addr_a; a2_a <= a1_a; a3_a <= a2_a;
    a1_b <= addr_b; a2_b <= a1_b; a3_b <= a2_b;
  end
  assign rd_a = word_at(int'(a3_a) - int'(BASE));
  assign rd_b = word_at(int'(a3_b) - int'(BASE));

  rgb_frame_reader u_a (
    .Clock_50       (clk),
    .Reset          (rst_a),
    .Start          (st_a),
    .SRAM_address   (addr_a),
    .SRAM_we_n      (we_a),
    .SRAM_read_data (rd_a),
    .Pix_valid      (va),
    .Pix_ready      (ra),
    .Pix_R          (r_a),
    .Pix_G          (g_a),
    .Pix_B          (b_a),
    .Busy           (busy_a),
    .Done           (done_a)
  );

  rgb_frame_reader #(
    .NUM_PIXELS (NP_B)
  ) u_b (
    .Clock_50       (clk),
    .Reset          (rst_b),
    .Start          (st_b),
    .SRAM_address   (addr_b),
    .SRAM_we_n      (we_b),
    .SRAM_read_data (rd_b),
    .Pix_valid      (vb),
    .Pix_ready      (rb),
    .Pix_R          (r_b),
    .Pix_G          (g_b),
    .Pix_B          (b_b),
    .Busy           (busy_b),
    .Done           (done_b)
  );

  int          rx_a = 0;
  int          rx_b = 0;
  int          n_done_b = 0;
  bit          mon_a = 0;
  bit          mon_b = 0;
  bit          occ_en = 0;
  bit          prev_done = 0;
  logic        busy_after = 1'b1;
  logic [17:0] max_addr_b = '0;

  always @(negedge clk) begin
    if (mon_a && va && ra) begin
      chk("pix_a", {8'h0, r_a, g_a, b_a},
          {8'h0, ref_pix(rx_a)});
      rx_a++;
    end
    if (occ_en) begin
      chk("occ_a", 32'(u_a.u_fifo.count <= 8), 32'd1);
    end
    if (mon_b) begin
      if (vb && rb) begin
        chk("pix_b", {8'h0, r_b, g_b, b_b},
            {8'h0, ref_pix(rx_b % NP_B)});
        rx_b++;
      end
      if (prev_done) busy_after = busy_b;
      prev_done = done_b;
      if (done_b) begin
        n_done_b++;
        chk("done_after_last", rx_b, NP_B);
      end
      if (addr_b > max_addr_b) max_addr_b = addr_b;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int lat;
  int n0;

  task automatic start_a_and_time(input string tag);
    lat  = 0;
    st_a = 1'b1;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick();
      st_a = 1'b0;
      if (va) lat = k;
    end
    chk(tag, lat, 6);
    chk({tag, "_p0"}, {8'h0, r_a, g_a, b_a}, 32'h112233);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    st_a  = 1'b0; st_b  = 1'b0;
    ra    = 1'b1; rb    = 1'b1;
    repeat (3) tick();
    chk("rst_addr", 32'(addr_a), 32'(BASE));
    chk("rst_we", 32'(we_a), 1);
    chk("rst_valid", 32'(va), 0);
    chk("rst_rgb", {8'h0, r_a, g_a, b_a}, 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);

    rst_a = 1'b0; rst_b = 1'b0;
    rx_a = 0; mon_a = 1;
    start_a_and_time("latency");
    tick();
    chk("p1", {8'h0, r_a, g_a, b_a}, 32'h445566);
    chk("busy_a", 32'(busy_a), 1);

    for (int k = 0; k < 1000 && rx_a < 100; k++) tick();
    chk("reach100", 32'(rx_a >= 100), 1);
    mon_a = 0;
    rst_a = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(va), 0);
    chk("mid_rst_busy", 32'(busy_a), 0);
    chk("mid_rst_addr", 32'(addr_a), 32'(BASE));
    rst_a = 1'b0;
    repeat (5) tick();
    chk("post_rst_idle", 32'(va), 0);

    rx_a = 0; mon_a = 1;
    start_a_and_time("latency2");
    repeat (30) tick();

    n0 = rx_a;
    st_a = 1'b1;
    tick();
    st_a = 1'b0;
    repeat (299) tick();
    chk("thru", 32'((rx_a - n0) >= 199 && (rx_a - n0) <= 201), 1);
    chk("busy_hold", 32'(busy_a), 1);

    occ_en = 1;
    ra = 1'b0;
    n0 = rx_a;
    repeat (40) tick();
    chk("stall_hold", rx_a, n0);
    chk("stall_valid", 32'(va), 1);
    ra = 1'b1;
    repeat (60) tick();
    chk("resume", 32'(rx_a > n0 + 30), 1);

    n0 = rx_a;
    repeat (1500) begin
      ra = ($urandom_range(0, 9) < 3);
      tick();
    end
    ra = 1'b1;
    repeat (50) tick();
    occ_en = 0;
    chk("rand_progress", 32'(rx_a - n0 >= 300), 1);

    mon_b = 1;
    st_b  = 1'b1;
    repeat (120) begin
      tick();
      st_b = 1'b0;
    end
    chk("we_b", 32'(we_b), 1);
`ifdef RGB_READER_LOOP_EN
    chk("loop_no_done", n_done_b, 0);
    chk("loop_repeats", 32'(rx_b >= 3 * NP_B), 1);
    chk("loop_busy", 32'(busy_b), 1);
`else
    chk("frame_pixels", rx_b, NP_B);
    chk("done_pulses", n_done_b, 1);
    chk("busy_after_done", 32'(busy_after), 0);
    chk("last_addr", 32'(max_addr_b), 32'd146955);
    chk("idle_busy", 32'(busy_b), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_frame_reader.md
RGB_FRAME_READER -- requirements
Module: rgb_frame_reader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 18'd146944, meaning the SRAM word address of the first packed RGB word.
REQ-002 SHALL have parameter NUM_PIXELS, default 76800 (320x240), meaning the pixels per frame; it SHALL be even.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning the pixel FIFO entries; it SHALL be a power of two and at least 4.
REQ-004 SHALL have parameter SRAM_LATENCY, default 3, meaning the cycles from address driven to SRAM_read_data valid.
REQ-005 Port: Clock_50, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 Port: Reset, input, 1 bit, synchronous active-high reset.
REQ-007 Port: Start, input, 1 bit, one-cycle pulse that begins a frame read.
REQ-008 Port: SRAM_address, output, 18 bits, the read address.
REQ-009 Port: SRAM_we_n, output, 1 bit, held 1 at all times (read-only block).
REQ-010 Port: SRAM_read_data, input, 16 bits, the packed RGB word.
REQ-011 Port: Pix_valid, output, 1 bit, the FIFO head holds a pixel.
REQ-012 Port: Pix_ready, input, 1 bit, the consumer accepts the pixel.
REQ-013 Port: Pix_R, Pix_G, Pix_B, outputs, 8 bits each, the head pixel.
REQ-014 Port: Busy, output, 1 bit, high whenever the block is not in IDLE.
REQ-015 Port: Done, output, 1 bit, one-cycle pulse after the last pixel has been consumed.

Function
REQ-016 Packing SHALL be: word 3k = {R(2k), G(2k)}; word 3k+1 = {B(2k), R(2k+1)}; word 3k+2 = {G(2k+1), B(2k+1)}; upper byte = [15:8].
REQ-017 The FSM SHALL have states IDLE, FETCH, DRAIN, DONE. IDLE goes to FETCH on Start; FETCH goes to DRAIN after the address of the final word (BASE_ADDR + 3*NUM_PIXELS/2 - 1) is issued; DRAIN goes to DONE when the FIFO is empty and nothing is in flight; DONE goes to IDLE after one cycle.
REQ-018 In FETCH, one address SHALL be issued per cycle only if (FIFO occupancy + pixels in flight + pixels pending in the unpacker) <= FIFO_DEPTH - 2; otherwise the address SHALL be held and no read counted.
REQ-019 An SRAM_LATENCY-deep valid shift register SHALL tag issued reads; the tagged data SHALL be captured in exactly the cycle the tag exits.
REQ-020 The unpacker SHALL use a 3-phase counter (0,1,2) advanced per captured word. Phase 0 SHALL latch R,G. Phase 1 SHALL push pixel 2k and latch R. Phase 2 SHALL push pixel 2k+1. The phase SHALL wrap 2 to 0.
REQ-021 The FIFO SHALL be a synchronous FIFO of 24-bit {R,G,B}. A pop SHALL occur when Pix_valid && Pix_ready. A push and a pop in the same cycle SHALL leave occupancy unchanged, and this SHALL be legal at full.
REQ-022 Pix_R/G/B SHALL reflect the FIFO head combinationally, with first-word fall-through.
REQ-023 The latency from Start to first Pix_valid SHALL be SRAM_LATENCY + 3 cycles when the FIFO is empty.
REQ-024 With Pix_ready held high, sustained throughput SHALL be 2 pixels per 3 cycles; no pixel SHALL be dropped or duplicated under any Pix_ready pattern.
REQ-025 Start SHALL be ignored while Busy is high.
REQ-026 The address counter SHALL be 18 bits and SHALL wrap only via reset or a new frame.

Reset
REQ-027 On Reset=1 at a clock edge, the block SHALL go to state IDLE and set SRAM_address=BASE_ADDR, SRAM_we_n=1, Pix_valid=0, Pix_R/G/B=0, Busy=0, Done=0.
REQ-028 On Reset=1, the FIFO pointers, unpacker phase and in-flight tags SHALL be cleared.
REQ-029 Reset mid-frame SHALL discard all in-flight data; SRAM data returning after reset SHALL be ignored.

Configuration
REQ-030 With RGB_READER_LOOP_EN defined, the block SHALL go from DRAIN to FETCH at BASE_ADDR without visiting DONE, so Done never pulses and Busy stays high after the first Start.
REQ-031 With RGB_READER_LOOP_EN undefined, behaviour SHALL be per REQ-017 (single frame).

Structure
REQ-032 Package rgb_reader_pkg SHALL hold the state enum (IDLE, FETCH, DRAIN, DONE), the pixel struct {R,G,B}, and the RGB_OFFSET constant 18'd146944.
REQ-033 The FIFO SHALL be sub-module pixel_fifo (parameterised depth and width, with full, empty and count outputs).

Verification
REQ-034 Scenario: SRAM model with words 0x1122, 0x3344, 0x5566 at 146944..146946, Pix_ready=1, Start pulse -> pixel 0 = (0x11,0x22,0x33) and pixel 1 = (0x44,0x55,0x66), first valid at cycle 6 after Start.
REQ-035 Scenario: NUM_PIXELS=8, Pix_ready=1 -> exactly 8 pixels, a single Done pulse, Busy falls the cycle after Done, and the last address is 146955.
REQ-036 Scenario: Pix_ready low for 40 cycles mid-frame -> occupancy never exceeds FIFO_DEPTH, and after release the pixel sequence is intact against the reference sequence.
REQ-037 Scenario: random Pix_ready at 30% duty over a full 76800-pixel frame -> scoreboard matches, with zero loss and zero duplication.
REQ-038 Scenario: Reset asserted at pixel 100 -> Pix_valid=0 the next cycle; a new Start then yields the frame again from pixel 0.
REQ-039 Scenario: RGB_READER_LOOP_EN defined, NUM_PIXELS=4 -> the pixel sequence repeats 0,1,2,3,0,1,2,3... with Done never asserted.
